multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multicycle control FSM that sequences the shared datapath: fetch, decode, execute, memory, writeback.
//  Drives the Extend unit's ImmSrc, plus ALU, register file, PC and memory controls. Owns the NZCV flag
//  register and handles conditional execution. Waits on a ready/request memory handshake.
//  Sits between the instruction register and the datapath. Only this block writes PC, register file and memory.
// PARAMETERS
//  PERF_W  32  width of the performance counters (used only when MCTRL_PERF_EN is defined)
// PORTS
//  clk         in   1   clock; all state updates on rising edge
//  reset_n     in   1   synchronous reset, active-low
//  Instr       in   32  IR contents: Cond=[31:28], Op=[27:26], I=[25], Cmd=[24:21], S/L=[20]
//  ALUFlags    in   4   NZCV from ALU, valid in EXECUTE cycles
//  MemReady    in   1   memory completes current access this cycle
//  MemReq      out  1   memory access request
//  MemWrite    out  1   store strobe (qualified by MemReady)
//  AdrSrc      out  1   0=PC, 1=ALU result as memory address
//  IRWrite     out  1   load IR
//  PCWrite     out  1   load PC with Result
//  RegWrite    out  1   register file write enable
//  ImmSrc      out  2   00 zero-ext 16b, 01 sign-ext 16b, 10 sign-ext 20b <<2
//  ALUSrcA     out  1   0=RegA, 1=PC
//  ALUSrcB     out  2   00=RegB, 01=ExtImm, 10=const 4
//  ALUControl  out  3   000 add, 001 sub, 010 and, 011 orr, 100 pass-B
//  ResultSrc   out  2   00=ALUOut reg, 01=MemData, 10=ALU direct
//  UndefInstr  out  1   1-cycle pulse in DECODE when Op=11
//  State       out  4   current state encoding (debug)
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state<=FETCH, Flags<=0000; while reset_n=0 every enable/MemReq=0 and
//   selects=0. Reset mid-access aborts the access. There are no partial writes.
//  FETCH: MemReq=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, add, ResultSrc=10. Stays in FETCH while MemReady=0.
//   When MemReady=1: IRWrite=1, PCWrite=1 (PC+4), next DECODE.
//  DECODE: CondEx is computed from the registered Flags and Cond (ARM table, 1110=always).
//   If !CondEx -> FETCH. If Op=11 -> UndefInstr=1, go to FETCH.
//   Op=00: I=1 -> EXECI, else EXECR. Op=01 -> MEMADR. Op=10 -> BRANCH.
//  EXECR/EXECI: ALUSrcA=0; ALUSrcB=00 (R) or 01 (I); ALUControl from Cmd.
//   ImmSrc=00 for logical Cmd (and/orr), 01 for arithmetic. If S=1, Flags<=ALUFlags at the end of this cycle.
//   Next ALUWB.
//  ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
//  MEMADR: ImmSrc=01, ALUSrcA=0, ALUSrcB=01, add. L=1 -> MEMREAD, else MEMWRITE.
//  MEMREAD: MemReq=1, AdrSrc=1. Holds until MemReady=1, then -> MEMWB.
//  MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
//  MEMWRITE: MemReq=1, AdrSrc=1, MemWrite=1. Holds until MemReady=1, then -> FETCH.
//  BRANCH: ImmSrc=10, ALUSrcA=1, ALUSrcB=01, add, ResultSrc=10, PCWrite=1 -> FETCH.
//  Outputs are Moore-decoded from state. Exceptions are Mealy-qualified by MemReady:
//   IRWrite and PCWrite in FETCH, plus UndefInstr.
//  Unused ImmSrc/ALU selects = 00. No state ever holds more than 1 cycle except the 3 memory-wait states.
//  Unreachable state encodings -> FETCH next cycle, all outputs 0.
// CONFIGURATION
//  MCTRL_PERF_EN defined: adds outputs CycleCount[PERF_W] and InstrCount[PERF_W], both 0 on reset.
//   CycleCount increments every non-reset cycle. InstrCount increments on each FETCH->DECODE transition.
//   Both wrap modulo 2^PERF_W.
//  MCTRL_PERF_EN undefined: the ports and counters are absent. FSM behaviour is identical.
// STRUCTURE
//  mctrl_pkg holds:
//   - state enum (FETCH..BRANCH, 4-bit);
//   - ImmSrc codes IMM_ZEXT16/IMM_SEXT16/IMM_BR20;
//   - Op codes;
//   - ALUControl codes;
//   - ALUSrcB/ResultSrc codes;
//   - Cond code constants.
//  Sub-module cond_check (combinational) maps Cond + Flags to CondEx.
// TESTING
//  1. reset_n=0 for 2 cycles in MEMREAD -> State=FETCH, all enables 0, Flags=0000, no RegWrite follows.
//  2. ADD imm, I=1, S=1, imm=0xFFFF, MemReady=1 ->
//     FETCH, DECODE, EXECI (ImmSrc=01), ALUWB (RegWrite=1), back to FETCH.
//     Takes 4 cycles. Flags latched from ALUFlags.
//  3. ORR imm, 0x8000 -> ImmSrc=00 in EXECI. Cmd=orr -> ALUControl=011.
//  4. LDR with MemReady low 3 cycles in MEMREAD -> MemReq=1 held, AdrSrc=1, then MEMWB RegWrite=1.
//     Total 8 cycles.
//  5. Branch with Cond=0000 (EQ):
//     - Flags Z=0 -> DECODE->FETCH, no PCWrite in DECODE;
//     - Z=1 -> BRANCH, ImmSrc=10, PCWrite=1.
//  6. Op=11 -> UndefInstr pulses once in DECODE, next FETCH, no writes. With MCTRL_PERF_EN, InstrCount +1.

Source files
------------

// File: rtl/mctrl_pkg.sv
// Shared types and encodings for the multicycle control FSM.
package mctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned FLAG_W  = 4;

  // Controller states; encodings 10..15 are unreachable.
  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXECR    = 4'd2,
    S_EXECI    = 4'd3,
    S_ALUWB    = 4'd4,
    S_MEMADR   = 4'd5,
    S_MEMREAD  = 4'd6,
    S_MEMWB    = 4'd7,
    S_MEMWRITE = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  // Extend unit selects
  localparam logic [1:0] IMM_ZEXT16 = 2'b00;
  localparam logic [1:0] IMM_SEXT16 = 2'b01;
  localparam logic [1:0] IMM_BR20   = 2'b10;

  // Instruction classes
  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  // ALU operations
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_ORR   = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;

  // ALU operand B and result muxes
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Data-processing Cmd field values
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  // Condition field values
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Map Cmd to ALU operation; unlisted commands fall back to add.
  function automatic logic [2:0] alu_from_cmd(input logic [3:0] cmd);
    case (cmd)
      CMD_AND: alu_from_cmd = ALU_AND;
      CMD_SUB: alu_from_cmd = ALU_SUB;
      CMD_ORR: alu_from_cmd = ALU_ORR;
      CMD_MOV: alu_from_cmd = ALU_PASSB;
      default: alu_from_cmd = ALU_ADD;
    endcase
  endfunction

  // Logical commands take a zero-extended immediate, arithmetic sign-extended.
  function automatic logic [1:0] imm_from_cmd(input logic [3:0] cmd);
    case (cmd)
      CMD_AND, CMD_ORR, CMD_MOV: imm_from_cmd = IMM_ZEXT16;
      default:                   imm_from_cmd = IMM_SEXT16;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_cond_check.sv
// Condition-code evaluator: Cond field against registered NZCV flags.
module multicycle_ctrl_cond_check
  import mctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags_i;

  // Standard ARM condition table; 1111 never executes.
  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_i)
      COND_EQ: cond_ex_o = z;
      COND_NE: cond_ex_o = ~z;
      COND_CS: cond_ex_o = c;
      COND_CC: cond_ex_o = ~c;
      COND_MI: cond_ex_o = n;
      COND_PL: cond_ex_o = ~n;
      COND_VS: cond_ex_o = v;
      COND_VC: cond_ex_o = ~v;
      COND_HI: cond_ex_o = c & ~z;
      COND_LS: cond_ex_o = ~c | z;
      COND_GE: cond_ex_o = (n == v);
      COND_LT: cond_ex_o = (n != v);
      COND_GT: cond_ex_o = ~z & (n == v);
      COND_LE: cond_ex_o = z | (n != v);
      COND_AL: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback sequencing,
// NZCV flag ownership and conditional execution.
// Optional MCTRL_PERF_EN adds cycle and retired-fetch counters.
module multicycle_ctrl
  import mctrl_pkg::*;
`ifdef MCTRL_PERF_EN
#(
  parameter int unsigned PERF_W = 32
)
`endif
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        MemReady,
  output logic        MemReq,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ResultSrc,
  output logic        UndefInstr,
  output logic [3:0]  State
`ifdef MCTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] CycleCount,
  output logic [PERF_W-1:0] InstrCount
`endif
);

  state_e             state_q, state_d;
  logic [FLAG_W-1:0]  flags_q;
  logic               flags_we;
  logic               cond_ex;

  logic [3:0] cond;
  logic [1:0] op;
  logic       i_bit;
  logic [3:0] cmd;
  logic       sl_bit;
  logic [19:0] unused_instr_low;

  assign cond             = Instr[31:28];
  assign op               = Instr[27:26];
  assign i_bit            = Instr[25];
  assign cmd              = Instr[24:21];
  assign sl_bit           = Instr[20];
  assign unused_instr_low = Instr[19:0];

  multicycle_ctrl_cond_check u_cond_check (
    .cond_i    (cond),
    .flags_i   (flags_q),
    .cond_ex_o (cond_ex)
  );

  // State register; reset aborts any in-flight access.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // NZCV register, loaded from the ALU by flag-setting data-processing ops.
  always_ff @(posedge clk) begin
    if (!reset_n)      flags_q <= '0;
    else if (flags_we) flags_q <= ALUFlags;
  end

  // Next-state and Moore outputs; fetch strobes and UndefInstr are Mealy.
  always_comb begin
    state_d    = state_q;
    flags_we   = 1'b0;
    MemReq     = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ImmSrc     = IMM_ZEXT16;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ALUControl = ALU_ADD;
    ResultSrc  = RES_ALUOUT;
    UndefInstr = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!cond_ex) begin
          state_d = S_FETCH;
        end else begin
          case (op)
            OP_DP:   state_d = i_bit ? S_EXECI : S_EXECR;
            OP_MEM:  state_d = S_MEMADR;
            OP_BR:   state_d = S_BRANCH;
            default: begin
              UndefInstr = 1'b1;
              state_d    = S_FETCH;
            end
          endcase
        end
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (state_q == S_EXECI) ? SRCB_IMM : SRCB_REG;
        ALUControl = alu_from_cmd(cmd);
        ImmSrc     = imm_from_cmd(cmd);
        flags_we   = sl_bit;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMADR: begin
        ImmSrc  = IMM_SEXT16;
        ALUSrcB = SRCB_IMM;
        state_d = sl_bit ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_MEM;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end
      S_BRANCH: begin
        ImmSrc    = IMM_BR20;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        PCWrite   = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset forces every strobe and select low.
    if (!reset_n) begin
      flags_we   = 1'b0;
      MemReq     = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      ImmSrc     = IMM_ZEXT16;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_REG;
      ALUControl = ALU_ADD;
      ResultSrc  = RES_ALUOUT;
      UndefInstr = 1'b0;
    end
  end

  assign State = state_q;

`ifdef MCTRL_PERF_EN
  logic [PERF_W-1:0] cycle_cnt_q, instr_cnt_q;

  // Free-running cycle counter and FETCH->DECODE counter, both wrapping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + PERF_W'(1);
      if (state_q == S_FETCH && MemReady) instr_cnt_q <= instr_cnt_q + PERF_W'(1);
    end
  end

  assign CycleCount = cycle_cnt_q;
  assign InstrCount = instr_cnt_q;
`endif

endmodule
